sbus_frame_assembler: RTL and testbench

Byte-to-frame stage between the serial receiver and the S.BUS channel decoder. It takes the receiver's one-cycle byte strobes and finds 25-byte S.BUS frames: header 0x0F, 22 data bytes, flags, footer. Each frame is checked against inter-byte gap timing and footer value. The 22 data bytes of a good frame go out atomically as eleven 16-bit words, which feed the decoder's in0..in10 directly, plus the flags byte, status bits and counters.

---
 rtl/sbus_frame_assembler.sv | 129 ++++++++++++
 tb/tb_sbus_frame_assembler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sbus_frame_assembler.sv
// Collects receiver byte strobes into 25-byte S.BUS frames, qualifies them on
// inter-byte gap timing and footer value, and publishes good frames atomically.
module sbus_frame_assembler #(
   parameter int GAP_CYCLES = 25000
) (
   input  logic         clk_clk,
   input  logic         reset_reset,
   input  logic         i_rx_dv,
   input  logic [7:0]   i_rx_byte,
   output logic [175:0] o_words,
   output logic [7:0]   o_flags,
   output logic         o_failsafe,
   output logic         o_frame_lost,
   output logic         o_frame_stb,
   output logic [15:0]  o_frame_count,
   output logic [15:0]  o_err_count
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
   localparam logic [GW-1:0] GAP_PRE = GW'(GAP_CYCLES - 1);
   localparam int NBYTES = 22;

   typedef enum logic [1:0] {HUNT, DATA, FLAGS, FOOTER} state_t;

   state_t          state_q;
   logic [4:0]      idx_q;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [7:0]      shadow_q [NBYTES];
   logic [7:0]      shadow_flags_q;
   logic [175:0]    shadow_words;
   logic [175:0]    words_q;
   logic [7:0]      flags_q;
   logic            failsafe_q, frame_lost_q, frame_stb_q;
   logic [15:0]     frame_cnt_q, err_cnt_q, err_cnt_d;
   logic            armed, timeout, footer_ok, err_inc;

   assign armed     = (gap_cnt_q == GAP_MAX);
   assign timeout   = (state_q != HUNT) && !i_rx_dv && (gap_cnt_q == GAP_PRE);
   // Plain S.BUS footer 0x00, or S.BUS2 footers 0x04/0x14/0x24/0x34.
   assign footer_ok = (i_rx_byte == 8'h00) ||
                      ((i_rx_byte[7:6] == 2'b00) && (i_rx_byte[3:0] == 4'h4));
   assign err_inc   = timeout || ((state_q == FOOTER) && i_rx_dv && !footer_ok);

   always_comb begin
      gap_cnt_d = gap_cnt_q;
      if (i_rx_dv)
         gap_cnt_d = '0;
      else if (gap_cnt_q != GAP_MAX)
         gap_cnt_d = gap_cnt_q + 1'b1;
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_inc && (err_cnt_q != 16'hFFFF))
         err_cnt_d = err_cnt_q + 16'd1;
   end

   for (genvar gi = 0; gi < NBYTES / 2; gi++) begin : g_pack
      assign shadow_words[16*gi +: 16] = {shadow_q[2*gi+1], shadow_q[2*gi]};
   end

   // Shadow storage holds the in-flight frame; its contents are irrelevant
   // until a valid footer copies it out, so it carries no reset.
   always_ff @(posedge clk_clk) begin
      if (i_rx_dv && (state_q == DATA))
         shadow_q[idx_q] <= i_rx_byte;
      if (i_rx_dv && (state_q == FLAGS))
         shadow_flags_q <= i_rx_byte;
   end

   always_ff @(posedge clk_clk or negedge reset_reset) begin
      if (!reset_reset) begin
         state_q      <= HUNT;
         idx_q        <= '0;
         gap_cnt_q    <= GAP_MAX;
         words_q      <= '0;
         flags_q      <= '0;
         failsafe_q   <= 1'b1;
         frame_lost_q <= 1'b0;
         frame_stb_q  <= 1'b0;
         frame_cnt_q  <= '0;
         err_cnt_q    <= '0;
      end else begin
         gap_cnt_q   <= gap_cnt_d;
         err_cnt_q   <= err_cnt_d;
         frame_stb_q <= 1'b0;
         if (timeout) begin
            state_q <= HUNT;
         end else if (i_rx_dv) begin
            case (state_q)
               HUNT: begin
                  if ((i_rx_byte == 8'h0F) && armed) begin
                     state_q <= DATA;
                     idx_q   <= '0;
                  end
               end
               DATA: begin
                  idx_q <= idx_q + 5'd1;
                  if (idx_q == 5'(NBYTES - 1))
                     state_q <= FLAGS;
               end
               FLAGS: state_q <= FOOTER;
               FOOTER: begin
                  state_q <= HUNT;
                  if (footer_ok) begin
                     words_q      <= shadow_words;
                     flags_q      <= shadow_flags_q;
                     failsafe_q   <= shadow_flags_q[3];
                     frame_lost_q <= shadow_flags_q[2];
                     frame_stb_q  <= 1'b1;
                     frame_cnt_q  <= frame_cnt_q + 16'd1;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign o_words       = words_q;
   assign o_flags       = flags_q;
   assign o_failsafe    = failsafe_q;
   assign o_frame_lost  = frame_lost_q;
   assign o_frame_stb   = frame_stb_q;
   assign o_frame_count = frame_cnt_q;
   assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_sbus_frame_assembler.sv
// Directed bench for sbus_frame_assembler with a short gap window (20 clocks).
module tb_sbus_frame_assembler;

   logic         clk_clk = 1'b0;
   logic         reset_reset = 1'b0;
   logic         i_rx_dv = 1'b0;
   logic [7:0]   i_rx_byte = 8'h00;
   logic [175:0] o_words;
   logic [7:0]   o_flags;
   logic         o_failsafe, o_frame_lost, o_frame_stb;
   logic [15:0]  o_frame_count, o_err_count;

   int checks = 0;
   int passes = 0;
   int stb_cnt = 0;

   sbus_frame_assembler #(.GAP_CYCLES(20)) dut (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .i_rx_dv       (i_rx_dv),
      .i_rx_byte     (i_rx_byte),
      .o_words       (o_words),
      .o_flags       (o_flags),
      .o_failsafe    (o_failsafe),
      .o_frame_lost  (o_frame_lost),
      .o_frame_stb   (o_frame_stb),
      .o_frame_count (o_frame_count),
      .o_err_count   (o_err_count)
   );

   always #5 clk_clk = ~clk_clk;

   always @(posedge clk_clk) if (o_frame_stb) stb_cnt++;

   task automatic check(input string tag, input logic [175:0] obs, input logic [175:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic send(input logic [7:0] b);
      i_rx_dv   = 1'b1;
      i_rx_byte = b;
      @(negedge clk_clk);
      i_rx_dv   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] base, input logic [7:0] flags, input logic [7:0] footer);
      send(8'h0F);
      for (int i = 0; i < 22; i++) send(base + 8'(i));
      send(flags);
      send(footer);
      $display("frame base=%0h flags=%0h footer=%0h -> stb=%0b fc=%0d ec=%0d",
               base, flags, footer, o_frame_stb, o_frame_count, o_err_count);
   endtask

   initial begin
      tick(3);
      check("rst_words", o_words, '0);
      check("rst_flags", 176'(o_flags), 176'h0);
      check("rst_failsafe", 176'(o_failsafe), 176'h1);
      check("rst_lost", 176'(o_frame_lost), 176'h0);
      check("rst_stb", 176'(o_frame_stb), 176'h0);
      check("rst_fc", 176'(o_frame_count), 176'h0);
      check("rst_ec", 176'(o_err_count), 176'h0);
      reset_reset = 1'b1;

      // Good frame after a long idle
      tick(25);
      send_frame(8'h01, 8'h08, 8'h00);
      check("f1_stb", 176'(o_frame_stb), 176'h1);
      check("f1_w0", 176'(o_words[15:0]), 176'h0201);
      check("f1_w10", 176'(o_words[175:160]), 176'h1615);
      check("f1_flags", 176'(o_flags), 176'h08);
      check("f1_failsafe", 176'(o_failsafe), 176'h1);
      check("f1_lost", 176'(o_frame_lost), 176'h0);
      check("f1_fc", 176'(o_frame_count), 176'h1);
      tick(1);
      check("f1_stb_low", 176'(o_frame_stb), 176'h0);
      check("f1_stb_cnt", 176'(stb_cnt), 176'h1);

      // Bad footer: outputs held, error counted
      tick(21);
      send_frame(8'h30, 8'h04, 8'h55);
      tick(1);
      check("bad_ec", 176'(o_err_count), 176'h1);
      check("bad_stb_cnt", 176'(stb_cnt), 176'h1);
      check("bad_w0", 176'(o_words[15:0]), 176'h0201);
      check("bad_flags", 176'(o_flags), 176'h08);
      check("bad_fc", 176'(o_frame_count), 176'h1);

      // Timeout after 10 data bytes, then immediate frame with S.BUS2 footer
      tick(21);
      send(8'h0F);
      for (int i = 0; i < 10; i++) send(8'h60 + 8'(i));
      tick(19);
      check("to_ec_before", 176'(o_err_count), 176'h1);
      tick(1);
      check("to_ec_after", 176'(o_err_count), 176'h2);
      send_frame(8'h40, 8'h04, 8'h24);
      check("f3_stb", 176'(o_frame_stb), 176'h1);
      check("f3_fc", 176'(o_frame_count), 176'h2);
      check("f3_w0", 176'(o_words[15:0]), 176'h4140);
      check("f3_w10", 176'(o_words[175:160]), 176'h5554);
      check("f3_failsafe", 176'(o_failsafe), 176'h0);
      check("f3_lost", 176'(o_frame_lost), 176'h1);

      // Stream of 0x0F with short gaps never arms
      for (int i = 0; i < 30; i++) begin
         send(8'h0F);
         tick(5);
      end
      $display("stream done stb_cnt=%0d fc=%0d ec=%0d", stb_cnt, o_frame_count, o_err_count);
      check("stream_stb_cnt", 176'(stb_cnt), 176'h2);
      check("stream_fc", 176'(o_frame_count), 176'h2);
      check("stream_ec", 176'(o_err_count), 176'h2);

      // Reset in the middle of a frame
      tick(21);
      send(8'h0F);
      for (int i = 0; i < 12; i++) send(8'h20 + 8'(i));
      #2 reset_reset = 1'b0;
      #1;
      check("mrst_words", o_words, '0);
      check("mrst_flags", 176'(o_flags), 176'h0);
      check("mrst_failsafe", 176'(o_failsafe), 176'h1);
      check("mrst_lost", 176'(o_frame_lost), 176'h0);
      check("mrst_fc", 176'(o_frame_count), 176'h0);
      check("mrst_ec", 176'(o_err_count), 176'h0);
      tick(2);
      reset_reset = 1'b1;
      tick(20);
      send_frame(8'h50, 8'h00, 8'h14);
      check("f4_fc", 176'(o_frame_count), 176'h1);
      check("f4_w5", 176'(o_words[95:80]), 176'h5B5A);
      check("f4_failsafe", 176'(o_failsafe), 176'h0);
      check("f4_lost", 176'(o_frame_lost), 176'h0);

      // Error counter saturation
      tick(1);
      force dut.err_cnt_q = 16'hFFFE;
      tick(1);
      release dut.err_cnt_q;
      tick(1);
      check("sat_preset", 176'(o_err_count), 176'hFFFE);
      for (int i = 0; i < 3; i++) begin
         tick(21);
         send(8'h0F);
         tick(20);
         $display("timeout %0d ec=%0h", i, o_err_count);
         if (i == 0) check("sat_first", 176'(o_err_count), 176'hFFFF);
      end
      check("sat_hold", 176'(o_err_count), 176'hFFFF);

      // Frame counter wraps
      force dut.frame_cnt_q = 16'hFFFF;
      tick(1);
      release dut.frame_cnt_q;
      tick(1);
      check("wrap_preset", 176'(o_frame_count), 176'hFFFF);
      tick(21);
      send_frame(8'h70, 8'h0C, 8'h00);
      check("wrap_fc", 176'(o_frame_count), 176'h0);
      check("wrap_failsafe", 176'(o_failsafe), 176'h1);
      check("wrap_lost", 176'(o_frame_lost), 176'h1);
      check("wrap_w0", 176'(o_words[15:0]), 176'h7170);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
